// File: rtl/ctrl_pkg.sv
// Shared definitions for the core step/burst enable sequencer.
package ctrl_pkg;

   // Controller states; the 2-bit encoding is fixed so debug tooling can decode it.
   typedef enum logic [1:0] {
      S_HALT  = 2'd0,
      S_RUN   = 2'd1,
      S_STEP  = 2'd2,
      S_BURST = 2'd3
   } state_e;

   // Plain-vector views of the same encoding for the state register.
   localparam logic [1:0] ST_HALT  = S_HALT;
   localparam logic [1:0] ST_RUN   = S_RUN;
   localparam logic [1:0] ST_STEP  = S_STEP;
   localparam logic [1:0] ST_BURST = S_BURST;

   // Default widths of the burst counter and the enabled-cycle counter.
   localparam int CNT_W_DEF  = 16;
   localparam int PERF_W_DEF = 32;

endpackage

// File: rtl/rise_detect.sv
// Registers a level request and flags its rising edge.
module rise_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic lvl,
   output logic lvl_q,
   output logic rise
);

   // Remember last cycle's level so a held request fires only once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) lvl_q <= 1'b0;
      else       lvl_q <= lvl;
   end

   assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/step_controller.sv
// Gated core clock-enable sequencer: free-run, halt, single-step, N-cycle burst.
module step_controller
   import ctrl_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int PERF_W = PERF_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              halt_i,
   input  logic              run_i,
   input  logic              step_i,
   input  logic              burst_i,
   input  logic [CNT_W-1:0]  burst_len_i,
   input  logic              clr_perf_i,
   output logic              cpu_en_o,
   output logic              halted_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  remaining_o,
   output logic [PERF_W-1:0] perf_cnt_o
);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              done_q;
   logic              done_nxt;
   logic              step_q;
   logic              step_rise;
   logic              burst_q;
   logic              burst_rise;
   logic [PERF_W-1:0] perf_q;

   // Next value of the enabled-cycle counter; clear wins over increment.
   function automatic logic [PERF_W-1:0] perf_next(input logic [PERF_W-1:0] cur,
                                                   input logic              clr,
                                                   input logic              en);
      if (clr)     return '0;
      else if (en) return cur + PERF_W'(1);
      else         return cur;
   endfunction

   rise_detect u_step_rise (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .lvl   (step_i),
      .lvl_q (step_q),
      .rise  (step_rise)
   );

   rise_detect u_burst_rise (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .lvl   (burst_i),
      .lvl_q (burst_q),
      .rise  (burst_rise)
   );

   // Next-state, burst count and completion decode; edges outside HALT are dropped.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         ST_HALT: begin
            if (halt_i) begin
               state_nxt = ST_HALT;
            end else if (run_i) begin
               state_nxt = ST_RUN;
            end else if (burst_rise) begin
               if (burst_len_i != '0) begin
                  state_nxt = ST_BURST;
                  cnt_nxt   = burst_len_i;
               end else begin
                  done_nxt  = 1'b1;
               end
            end else if (step_rise) begin
               state_nxt = ST_STEP;
            end
         end
         ST_RUN: begin
            if (halt_i || !run_i) state_nxt = ST_HALT;
         end
         ST_STEP: begin
            state_nxt = ST_HALT;
            done_nxt  = 1'b1;
         end
         ST_BURST: begin
            if (halt_i) begin
               state_nxt = ST_HALT;
               cnt_nxt   = '0;
            end else if (run_i) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else if (cnt == CNT_W'(1)) begin
               state_nxt = ST_HALT;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt   = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_HALT;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Control state: FSM, burst counter and registered done pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= ST_HALT;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         done_q <= done_nxt;
      end
   end

   // Count cycles in which the core was enabled.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) perf_q <= '0;
      else       perf_q <= perf_next(perf_q, clr_perf_i, cpu_en_o);
   end

   // Moore outputs decoded from registers only, so the enable cannot glitch.
   assign cpu_en_o    = (state != ST_HALT);
   assign halted_o    = (state == ST_HALT);
   assign done_o      = done_q;
   assign remaining_o = cnt;
   assign perf_cnt_o  = perf_q;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with a budget-based reference model.
module tb_step_controller;

   localparam int CNT_W  = 16;
   localparam int PERF_W = 32;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              halt_i = 1'b0;
   logic              run_i = 1'b0;
   logic              step_i = 1'b0;
   logic              burst_i = 1'b0;
   logic [CNT_W-1:0]  burst_len_i = '0;
   logic              clr_perf_i = 1'b0;
   logic              cpu_en_o;
   logic              halted_o;
   logic              done_o;
   logic [CNT_W-1:0]  remaining_o;
   logic [PERF_W-1:0] perf_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   step_controller #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .halt_i      (halt_i),
      .run_i       (run_i),
      .step_i      (step_i),
      .burst_i     (burst_i),
      .burst_len_i (burst_len_i),
      .clr_perf_i  (clr_perf_i),
      .cpu_en_o    (cpu_en_o),
      .halted_o    (halted_o),
      .done_o      (done_o),
      .remaining_o (remaining_o),
      .perf_cnt_o  (perf_cnt_o)
   );

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the core is enabled while free-running or while an
   // enable budget (step = 1, burst = N) is left; budgets end with done.
   bit              m_free;
   int              m_left;
   bit              m_burst;
   bit              m_done;
   logic [PERF_W-1:0] m_perf;
   bit              m_ps, m_pb;
   bit              t_en, t_sr, t_br, t_done, t_free, t_burst;
   int              t_left;

   function automatic bit model_en();
      return m_free || (m_left > 0);
   endfunction

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_free <= 0; m_left <= 0; m_burst <= 0; m_done <= 0;
         m_perf <= '0; m_ps <= 0; m_pb <= 0;
      end else begin
         t_en    = model_en();
         t_sr    = step_i && !m_ps;
         t_br    = burst_i && !m_pb;
         t_done  = 0;
         t_free  = m_free;
         t_left  = m_left;
         t_burst = m_burst;
         if (!t_en) begin
            if (halt_i) begin
               t_free = 0;
            end else if (run_i) begin
               t_free = 1;
            end else if (t_br) begin
               if (burst_len_i != 0) begin t_left = int'(burst_len_i); t_burst = 1; end
               else t_done = 1;
            end else if (t_sr) begin
               t_left = 1; t_burst = 0;
            end
         end else if (t_free) begin
            if (halt_i || !run_i) t_free = 0;
         end else if (!t_burst) begin
            t_left = 0; t_done = 1;
         end else begin
            if (halt_i) begin t_left = 0; t_burst = 0; end
            else if (run_i) begin t_left = 0; t_burst = 0; t_free = 1; end
            else if (t_left == 1) begin t_left = 0; t_burst = 0; t_done = 1; end
            else t_left = t_left - 1;
         end
         m_free  <= t_free;
         m_left  <= t_left;
         m_burst <= t_burst;
         m_done  <= t_done;
         m_perf  <= clr_perf_i ? '0 : m_perf + PERF_W'(t_en);
         m_ps    <= step_i;
         m_pb    <= burst_i;
      end
   end

   // Every cycle outside reset, the DUT must match the model.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         chk("cyc cpu_en", cpu_en_o, model_en());
         chk("cyc halted", halted_o, !model_en());
         chk("cyc done", done_o, m_done);
         chk("cyc remaining", remaining_o, m_burst ? m_left : 0);
         chk("cyc perf", perf_cnt_o, m_perf);
      end
   end

   int en_cnt, done_cnt, rem_idx;
   int rem_log [16];

   task automatic clr_counts();
      en_cnt = 0; done_cnt = 0; rem_idx = 0;
   endtask

   task automatic tick();
      @(negedge clk_i);
      en_cnt   += int'(cpu_en_o);
      done_cnt += int'(done_o);
      if (cpu_en_o && rem_idx < 16) begin
         rem_log[rem_idx] = int'(remaining_o);
         rem_idx++;
      end
   endtask

   task automatic clr_perf();
      clr_perf_i = 1'b1; tick(); clr_perf_i = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      chk("rst cpu_en", cpu_en_o, 0);
      chk("rst halted", halted_o, 1);
      chk("rst done", done_o, 0);
      chk("rst remaining", remaining_o, 0);
      chk("rst perf", perf_cnt_o, 0);
      rst_i = 1'b0;

      // Held step: one enabled cycle, one done, no retrigger.
      clr_counts(); step_i = 1'b1;
      repeat (10) tick();
      chk("step en cycles", en_cnt, 1);
      chk("step done pulses", done_cnt, 1);
      chk("step perf", perf_cnt_o, 1);
      step_i = 1'b0; tick();

      // Burst of 5 with countdown.
      clr_perf(); clr_counts();
      burst_len_i = 16'd5; burst_i = 1'b1;
      repeat (8) tick();
      chk("burst5 en cycles", en_cnt, 5);
      chk("burst5 done pulses", done_cnt, 1);
      chk("burst5 perf", perf_cnt_o, 5);
      chk("burst5 remaining end", remaining_o, 0);
      for (int i = 0; i < 5; i++) chk("burst5 countdown", rem_log[i], 5 - i);
      burst_i = 1'b0; tick();

      // Burst of 100 cut by halt in the 3rd enabled cycle.
      clr_perf(); clr_counts();
      burst_len_i = 16'd100; burst_i = 1'b1;
      repeat (3) tick();
      halt_i = 1'b1; tick();
      chk("halt cpu_en", cpu_en_o, 0);
      chk("halt remaining", remaining_o, 0);
      chk("halt perf", perf_cnt_o, 3);
      repeat (2) tick();
      chk("halt en cycles", en_cnt, 3);
      chk("halt done pulses", done_cnt, 0);
      halt_i = 1'b0; burst_i = 1'b0; tick();

      // Simultaneous step and burst edges: burst wins.
      clr_perf(); clr_counts();
      burst_len_i = 16'd2; step_i = 1'b1; burst_i = 1'b1;
      repeat (5) tick();
      chk("both en cycles", en_cnt, 2);
      chk("both done pulses", done_cnt, 1);
      chk("both perf", perf_cnt_o, 2);
      step_i = 1'b0; burst_i = 1'b0; tick();

      // Zero-length burst: no enable, one done.
      clr_counts();
      burst_len_i = 16'd0; burst_i = 1'b1;
      repeat (4) tick();
      chk("zero en cycles", en_cnt, 0);
      chk("zero done pulses", done_cnt, 1);
      burst_i = 1'b0; tick();

      // Free-run for 20 cycles with step edges injected.
      clr_perf(); clr_counts();
      run_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 5 || i == 12) step_i = 1'b1;
         if (i == 7 || i == 14) step_i = 1'b0;
         tick();
      end
      run_i = 1'b0;
      repeat (3) tick();
      chk("run en cycles", en_cnt, 20);
      chk("run done pulses", done_cnt, 0);
      chk("run perf", perf_cnt_o, 20);

      // Clear during an enabled cycle wins over the increment.
      run_i = 1'b1; repeat (3) tick();
      clr_perf_i = 1'b1; tick();
      chk("clr perf zero", perf_cnt_o, 0);
      chk("clr cpu_en", cpu_en_o, 1);
      clr_perf_i = 1'b0; tick();
      chk("clr perf resume", perf_cnt_o, 1);
      run_i = 1'b0; tick();

      // Asynchronous reset in the middle of a burst.
      burst_len_i = 16'd50; burst_i = 1'b1;
      repeat (4) tick();
      chk("pre-rst remaining", remaining_o, 47);
      @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      chk("arst cpu_en", cpu_en_o, 0);
      chk("arst halted", halted_o, 1);
      chk("arst remaining", remaining_o, 0);
      chk("arst perf", perf_cnt_o, 0);
      chk("arst done", done_o, 0);
      halt_i = 1'b1;
      repeat (2) tick();
      rst_i = 1'b0;
      tick();
      halt_i = 1'b0;
      clr_counts();
      repeat (6) tick();
      chk("post-rst en cycles", en_cnt, 0);
      chk("post-rst done pulses", done_cnt, 0);
      chk("post-rst remaining", remaining_o, 0);
      burst_i = 1'b0; tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
